idct_module: RTL and testbench

Inverse DCT stage for the MFCC path: collects one frame of 32 cepstral coefficients (INT16 Q4, the DCT stage's output format) and reconstructs the 32 log-mel energies (INT16 Q11, the DCT stage's input format). It is used for feature reconstruction and liftering checks, and as a loop-back partner of the DCT stage. It has a streaming input and a valid/ready output with backpressure. One multiply-accumulate unit is time-shared over all coefficients.

---
 rtl/idct_module.sv | 188 ++++++++++++++++++
 tb/tb_idct_module.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_module.sv
// 32-point inverse DCT for the MFCC path: buffers one frame of Q4 cepstral
// coefficients, then rebuilds each Q11 log-mel value with one time-shared MAC.
module idct_module #(
    parameter int N     = 32,
    parameter int Q_IN  = 4,
    parameter int Q_OUT = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] cep_in_i,
    input  logic               cep_valid_i,
    output logic               cep_ready_o,
    output logic signed [15:0] log_out_o,
    output logic               log_valid_o,
    output logic               log_last_o,
    input  logic               log_ready_i
);

    // Q(IN) * Q15 products carry 15+Q_IN fraction bits; this many are dropped to reach Q_OUT.
    localparam int                 SHIFT = 15 + Q_IN - Q_OUT;
    localparam logic signed [39:0] ROUND = 40'sd1 <<< (SHIFT - 1);
    localparam logic [4:0]         LAST  = 5'(N - 1);
    localparam logic signed [15:0] W_DC  = 16'sd5793;

    typedef enum logic [1:0] {LOAD, MAC, DRAIN, OUT} state_e;

    state_e             state_q, state_d;
    logic [4:0]         k_q, n_q;
    logic signed [15:0] coef_q [N];
    logic signed [39:0] acc_q;
    logic signed [31:0] prod_q;
    logic signed [15:0] log_out_q;
    logic               log_valid_q, log_last_q;

    logic               accept_w;
    logic [6:0]         m_w;
    logic [5:0]         rom_idx_w;
    logic               negate_w;
    logic signed [15:0] cos_w, weight_w;
    logic signed [39:0] sum_w, shifted_w;
    logic signed [15:0] sat_w;

    function automatic logic signed [15:0] cos_rom(input logic [5:0] idx);
        case (idx)
            6'd0:  cos_rom = 16'sd8192;
            6'd1:  cos_rom = 16'sd8182;
            6'd2:  cos_rom = 16'sd8153;
            6'd3:  cos_rom = 16'sd8103;
            6'd4:  cos_rom = 16'sd8035;
            6'd5:  cos_rom = 16'sd7946;
            6'd6:  cos_rom = 16'sd7839;
            6'd7:  cos_rom = 16'sd7713;
            6'd8:  cos_rom = 16'sd7568;
            6'd9:  cos_rom = 16'sd7405;
            6'd10: cos_rom = 16'sd7225;
            6'd11: cos_rom = 16'sd7027;
            6'd12: cos_rom = 16'sd6811;
            6'd13: cos_rom = 16'sd6580;
            6'd14: cos_rom = 16'sd6333;
            6'd15: cos_rom = 16'sd6070;
            6'd16: cos_rom = 16'sd5793;
            6'd17: cos_rom = 16'sd5501;
            6'd18: cos_rom = 16'sd5197;
            6'd19: cos_rom = 16'sd4880;
            6'd20: cos_rom = 16'sd4551;
            6'd21: cos_rom = 16'sd4212;
            6'd22: cos_rom = 16'sd3862;
            6'd23: cos_rom = 16'sd3503;
            6'd24: cos_rom = 16'sd3135;
            6'd25: cos_rom = 16'sd2760;
            6'd26: cos_rom = 16'sd2378;
            6'd27: cos_rom = 16'sd1990;
            6'd28: cos_rom = 16'sd1598;
            6'd29: cos_rom = 16'sd1202;
            6'd30: cos_rom = 16'sd803;
            6'd31: cos_rom = 16'sd402;
            default: cos_rom = 16'sd0;
        endcase
    endfunction

    assign accept_w = cep_valid_i && cep_ready_o;

    // Phase index (2n+1)k wraps naturally at 128, i.e. one full cosine period.
    assign m_w = 7'({n_q, 1'b1}) * 7'(k_q);

    always_comb begin
        rom_idx_w = m_w[5:0];
        negate_w  = 1'b0;
        if (m_w <= 7'd32) begin
            rom_idx_w = m_w[5:0];
        end else if (m_w <= 7'd64) begin
            rom_idx_w = 6'(7'd64 - m_w);
            negate_w  = 1'b1;
        end else if (m_w <= 7'd96) begin
            rom_idx_w = 6'(m_w - 7'd64);
            negate_w  = 1'b1;
        end else begin
            rom_idx_w = 6'(8'd128 - {1'b0, m_w});
        end
    end

    assign cos_w    = cos_rom(rom_idx_w);
    assign weight_w = (k_q == 5'd0) ? W_DC : (negate_w ? -cos_w : cos_w);

    assign sum_w     = acc_q + 40'(prod_q) + ROUND;
    assign shifted_w = sum_w >>> SHIFT;

    always_comb begin
        if (shifted_w > 40'sd32767)
            sat_w = 16'sh7FFF;
        else if (shifted_w < -40'sd32768)
            sat_w = 16'sh8000;
        else
            sat_w = shifted_w[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (accept_w && k_q == LAST) state_d = MAC;
            MAC:     if (k_q == LAST) state_d = DRAIN;
            DRAIN:   state_d = OUT;
            OUT:     if (log_ready_i) state_d = (n_q == LAST) ? LOAD : MAC;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        cep_ready_o = rst_n && (state_q == LOAD);
        log_out_o   = log_out_q;
        log_valid_o = log_valid_q;
        log_last_o  = log_last_q;
    end

    always_ff @(posedge clk) begin
        if (accept_w)
            coef_q[k_q] <= cep_in_i;
    end

    // The product pipeline lags one cycle, so DRAIN folds the last product in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            log_out_q   <= '0;
            log_valid_q <= 1'b0;
            log_last_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept_w) begin
                        k_q <= k_q + 5'd1;
                        if (k_q == LAST)
                            n_q <= '0;
                    end
                end
                MAC: begin
                    prod_q <= 32'(coef_q[k_q]) * 32'(weight_w);
                    acc_q  <= (k_q == 5'd0) ? 40'sd0 : acc_q + 40'(prod_q);
                    k_q    <= k_q + 5'd1;
                end
                DRAIN: begin
                    log_out_q   <= sat_w;
                    log_valid_q <= 1'b1;
                    log_last_q  <= (n_q == LAST);
                end
                OUT: begin
                    if (log_ready_i) begin
                        log_valid_q <= 1'b0;
                        log_last_q  <= 1'b0;
                        n_q         <= n_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_idct_module.sv
// Directed bench for idct_module: impulse frames with hand-derived outputs,
// saturation, latency, backpressure and asynchronous reset.
module tb_idct_module;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] cep_in;
    logic               cep_valid;
    logic               cep_ready;
    logic signed [15:0] log_out;
    logic               log_valid;
    logic               log_last;
    logic               log_ready;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int e0     = 0;

    logic signed [15:0] frame [32];
    int                 got_val  [32];
    logic               got_last [32];
    int                 got_cyc  [32];

    idct_module dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cep_in_i    (cep_in),
        .cep_valid_i (cep_valid),
        .cep_ready_o (cep_ready),
        .log_out_o   (log_out),
        .log_valid_o (log_valid),
        .log_last_o  (log_last),
        .log_ready_i (log_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic clear_frame();
        for (int i = 0; i < 32; i++) frame[i] = 16'sd0;
    endtask

    // Drives frame[] with valid held high; e0 marks the cycle just after X[31] is taken.
    task automatic send_frame();
        int k = 0;
        int guard = 0;
        while (k < 32 && guard < 500) begin
            @(negedge clk);
            guard++;
            cep_valid = 1'b1;
            cep_in    = frame[k];
            if (cep_ready === 1'b1) k++;
        end
        @(negedge clk);
        cep_valid = 1'b0;
        e0 = cycle;
        if (k < 32) begin
            checks++; errors++;
            $display("[TB] FAIL send_timeout: accepted %0d inputs, expected 32", k);
        end
    endtask

    task automatic collect(input int count);
        int idx = 0;
        int guard = 0;
        while (idx < count && guard < count * 60) begin
            @(negedge clk);
            guard++;
            if (log_valid === 1'b1 && log_ready === 1'b1) begin
                got_val[idx]  = log_out;
                got_last[idx] = log_last;
                got_cyc[idx]  = cycle;
                idx++;
            end
        end
        if (idx < count) begin
            checks++; errors++;
            $display("[TB] FAIL collect_timeout: got %0d outputs, expected %0d", idx, count);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (log_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", log_valid); end
        checks++; if (log_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", log_last); end
        checks++; if (log_out !== 16'sd0) begin errors++; $display("[TB] FAIL reset_out: got %0d expected 0", log_out); end
        checks++; if (cep_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready_low: got %b expected 0", cep_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (cep_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_ready: got %b expected 1", cep_ready); end
        // Partial frame that must be discarded by the reset below.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cep_valid = 1'b1;
            cep_in    = 16'(100 + k);
        end
        @(negedge clk);
        cep_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cep_ready !== 1'b0) begin errors++; $display("[TB] FAIL midframe_reset_ready: got %b expected 0", cep_ready); end
        checks++; if (log_valid !== 1'b0) begin errors++; $display("[TB] FAIL midframe_reset_valid: got %b expected 0", log_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (cep_ready !== 1'b1) begin errors++; $display("[TB] FAIL midframe_release_ready: got %b expected 1", cep_ready); end
    endtask

    task automatic test_dc_impulse();
        clear_frame();
        frame[0] = 16'sd16;
        log_ready = 1'b1;
        send_frame();
        collect(32);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_val[i] != 362) begin errors++; $display("[TB] FAIL dc_val[%0d]: got %0d expected 362", i, got_val[i]); end
            checks++;
            if (got_last[i] !== (i == 31)) begin errors++; $display("[TB] FAIL dc_last[%0d]: got %b expected %b", i, got_last[i], (i == 31)); end
        end
        checks++;
        if (got_cyc[0] - e0 != 33) begin errors++; $display("[TB] FAIL dc_latency: got %0d expected 33", got_cyc[0] - e0); end
        for (int i = 1; i < 32; i++) begin
            checks++;
            if (got_cyc[i] - got_cyc[i-1] != 34) begin errors++; $display("[TB] FAIL dc_spacing[%0d]: got %0d expected 34", i, got_cyc[i] - got_cyc[i-1]); end
        end
        checks++; if (cep_ready !== 1'b0) begin errors++; $display("[TB] FAIL dc_ready_in_out: got %b expected 0", cep_ready); end
        @(negedge clk);
        checks++; if (cep_ready !== 1'b1) begin errors++; $display("[TB] FAIL dc_ready_after_frame: got %b expected 1", cep_ready); end
        checks++; if (log_valid !== 1'b0) begin errors++; $display("[TB] FAIL dc_valid_after_frame: got %b expected 0", log_valid); end
    endtask

    task automatic test_first_harmonic();
        clear_frame();
        frame[1] = 16'sd16;
        log_ready = 1'b1;
        send_frame();
        collect(32);
        checks++; if (got_val[0] != 511) begin errors++; $display("[TB] FAIL h1_x0: got %0d expected 511", got_val[0]); end
        checks++; if (got_val[1] != 506) begin errors++; $display("[TB] FAIL h1_x1: got %0d expected 506", got_val[1]); end
        checks++; if (got_val[15] != 25) begin errors++; $display("[TB] FAIL h1_x15: got %0d expected 25", got_val[15]); end
        checks++; if (got_val[16] != -25) begin errors++; $display("[TB] FAIL h1_x16: got %0d expected -25", got_val[16]); end
        checks++; if (got_val[31] != -511) begin errors++; $display("[TB] FAIL h1_x31: got %0d expected -511", got_val[31]); end
    endtask

    task automatic test_saturation();
        clear_frame();
        frame[0] = 16'sh7FFF;
        log_ready = 1'b1;
        send_frame();
        collect(32);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_val[i] != 32767) begin errors++; $display("[TB] FAIL sat_pos[%0d]: got %0d expected 32767", i, got_val[i]); end
        end
        frame[0] = 16'sh8000;
        send_frame();
        collect(32);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_val[i] != -32768) begin errors++; $display("[TB] FAIL sat_neg[%0d]: got %0d expected -32768", i, got_val[i]); end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int guard = 0;
        int hcyc = 0;
        clear_frame();
        frame[0] = 16'sd16;
        log_ready = 1'b1;
        send_frame();
        while (idx < 32 && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (log_valid === 1'b1 && log_ready === 1'b1) begin
                if (idx == 3) begin
                    log_ready = 1'b0;
                    cep_valid = 1'b1;
                    cep_in    = 16'sd555;
                    for (int s = 0; s < 10; s++) begin
                        @(negedge clk);
                        guard++;
                        checks++;
                        if (log_valid !== 1'b1 || log_out !== 16'sd362) begin
                            errors++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b out=%0d expected valid=1 out=362", s, log_valid, log_out);
                        end
                        checks++;
                        if (cep_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", s, cep_ready); end
                    end
                    log_ready = 1'b1;
                    @(negedge clk);
                    hcyc = cycle;
                    cep_valid = 1'b0;
                    checks++;
                    if (log_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drop: got %b expected 0", log_valid); end
                end else begin
                    checks++;
                    if (log_out !== 16'sd362) begin errors++; $display("[TB] FAIL bp_val[%0d]: got %0d expected 362", idx, log_out); end
                    if (idx == 4) begin
                        checks++;
                        if (cycle - hcyc != 33) begin errors++; $display("[TB] FAIL bp_restart: got %0d expected 33", cycle - hcyc); end
                    end
                end
                idx++;
            end
        end
        if (idx < 32) begin
            checks++; errors++;
            $display("[TB] FAIL bp_timeout: got %0d outputs expected 32", idx);
        end
    endtask

    task automatic test_reset_mid_mac();
        int leftovers = 0;
        clear_frame();
        frame[0] = -16'sd16;
        frame[3] = 16'sd77;
        log_ready = 1'b1;
        send_frame();
        collect(5);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (log_valid !== 1'b0) begin errors++; $display("[TB] FAIL mac_reset_valid: got %b expected 0", log_valid); end
        checks++; if (cep_ready !== 1'b0) begin errors++; $display("[TB] FAIL mac_reset_ready: got %b expected 0", cep_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (cep_ready !== 1'b1) begin errors++; $display("[TB] FAIL mac_release_ready: got %b expected 1", cep_ready); end
        clear_frame();
        frame[0] = 16'sd16;
        send_frame();
        collect(32);
        checks++;
        if (got_cyc[0] - e0 != 33) begin errors++; $display("[TB] FAIL mac_reset_latency: got %0d expected 33", got_cyc[0] - e0); end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (got_val[i] != 362) begin errors++; $display("[TB] FAIL mac_reset_val[%0d]: got %0d expected 362", i, got_val[i]); end
        end
        repeat (40) begin
            @(negedge clk);
            if (log_valid === 1'b1) leftovers++;
        end
        checks++;
        if (leftovers != 0) begin errors++; $display("[TB] FAIL mac_reset_leftover: got %0d valid cycles expected 0", leftovers); end
    endtask

    initial begin
        rst_n     = 1'b0;
        cep_valid = 1'b0;
        cep_in    = 16'sd0;
        log_ready = 1'b0;
        test_reset();
        test_dc_impulse();
        test_first_harmonic();
        test_saturation();
        test_backpressure();
        test_reset_mid_mac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
